branch_pc_unit: RTL

- Next-PC stage directly downstream of the branch comparator in the single-cycle RV32I core.
- Decodes branch funct3 and drives the comparator's unsigned-select.
- Consumes the comparator's eq/lt flags and resolves branch, JAL and JALR.
- Owns the PC register, the instruction-fetch request handshake, the misaligned-target trap and a taken-branch counter.

---
 rtl/core_pkg.sv | 31 +++
 rtl/branch_cond.sv | 42 ++++
 rtl/branch_pc_unit.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_pkg
// Description : Shared definitions for the RV32I next-PC stage: branch funct3
//               encodings, the next-PC sequencer state encoding and the
//               default reset / trap-vector addresses.
// Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

    // B-type funct3 encodings (010 and 011 are unused by RV32I)
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Default PC on reset and default trap vector
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VEC = 32'h0000_0100;

    // Next-PC sequencer states, explicitly encoded
    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_TRAP = 2'd2
    } pcState_t;

endpackage : core_pkg
`default_nettype wire

// File: rtl/branch_cond.sv
`default_nettype none
// ============================================================================
// Module      : branch_cond
// Description : Purely combinational branch-condition evaluator. Maps the
//               B-type funct3 and the comparator flags to a taken condition
//               and flags the two unused funct3 encodings as illegal.
// Ports       : funct3  in  3  instruction funct3
//               br_eq   in  1  comparator equality flag
//               br_lt   in  1  comparator less-than flag (signedness chosen
//                              upstream through br_un)
//               cond    out 1  branch condition holds
//               illegal out 1  funct3 is not a valid branch encoding
// Revision    : 1.0 - initial release
// ============================================================================
module branch_cond
    import core_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       br_eq,
    input  logic       br_lt,
    output logic       cond,
    output logic       illegal
);

    // Signed and unsigned variants share br_lt; the comparator already
    // applied the unsigned select, so BLT/BLTU and BGE/BGEU decode alike.
    always_comb begin
        cond    = 1'b0;
        illegal = 1'b0;
        case (funct3)
            F3_BEQ:  cond = br_eq;
            F3_BNE:  cond = ~br_eq;
            F3_BLT:  cond = br_lt;
            F3_BGE:  cond = ~br_lt;
            F3_BLTU: cond = br_lt;
            F3_BGEU: cond = ~br_lt;
            default: illegal = 1'b1;
        endcase
    end

endmodule : branch_cond
`default_nettype wire

// File: rtl/branch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_pc_unit
// Description : Next-PC stage of the single-cycle RV32I core. Drives the
//               comparator unsigned select, resolves branches, JAL and JALR,
//               owns the PC register, the fetch handshake, the misaligned /
//               illegal-branch trap and a taken-transfer counter.
// Ports       : clk, rst_n                 clock, sync active-low reset
//               is_branch/is_jal/is_jalr   instruction class
//               funct3, imm, rs1_data      instruction fields / operands
//               br_eq, br_lt -> br_un      comparator interface
//               imem_ready -> imem_req     fetch handshake
//               stall                      external hold (RUN/WAIT only)
//               trap_ack -> trap_valid, trap_pc   trap handshake
//               pc, pc_plus4, br_taken, br_cnt    PC and status outputs
// Revision    : 1.0 - initial release
// ============================================================================
module branch_pc_unit
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] TRAP_VEC = DEFAULT_TRAP_VEC,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            is_branch,
    input  logic            is_jal,
    input  logic            is_jalr,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_data,
    input  logic            br_eq,
    input  logic            br_lt,
    output logic            br_un,
    input  logic            imem_ready,
    input  logic            stall,
    input  logic            trap_ack,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            imem_req,
    output logic            br_taken,
    output logic            trap_valid,
    output logic [XLEN-1:0] trap_pc,
    output logic [31:0]     br_cnt
);

    // JALR clears bit 0 of the computed target
    localparam logic [XLEN-1:0] C_JALR_MASK = {{(XLEN-1){1'b1}}, 1'b0};
    localparam logic [XLEN-1:0] C_FOUR      = XLEN'(4);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    pcState_t        r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_trapValid;
    logic [XLEN-1:0] r_trapPc;
    logic [31:0]     r_brCnt;

    pcState_t        w_stateNext;
    logic [XLEN-1:0] w_pcNext;
    logic            w_trapValidNext;
    logic [XLEN-1:0] w_trapPcNext;
    logic [31:0]     w_brCntNext;

    // ------------------------------------------------------------------------
    // Branch resolution datapath
    // ------------------------------------------------------------------------
    logic            w_cond;
    logic            w_illegal;
    logic            w_take;
    logic            w_fault;
    logic [XLEN-1:0] w_pcPlus4;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_seqNext;

    branch_cond u_branchCond (
        .funct3  (funct3),
        .br_eq   (br_eq),
        .br_lt   (br_lt),
        .cond    (w_cond),
        .illegal (w_illegal)
    );

    assign w_pcPlus4 = r_pc + C_FOUR;
    assign w_take    = is_jal | is_jalr | (is_branch & w_cond);

    // JALR is register-relative; branches and JAL are PC-relative
    assign w_target  = is_jalr ? ((rs1_data + imm) & C_JALR_MASK)
                               : (r_pc + imm);

    assign w_seqNext = w_take ? w_target : w_pcPlus4;

    // Only bit 1 can misalign a target: bit 0 is either cleared (JALR) or
    // always zero in B/J immediates.
    assign w_fault   = (w_take & w_target[1]) | (is_branch & w_illegal);

    // ------------------------------------------------------------------------
    // Next-state / next-value logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_stateNext     = r_state;
        w_pcNext        = r_pc;
        w_trapValidNext = r_trapValid;
        w_trapPcNext    = r_trapPc;
        w_brCntNext     = r_brCnt;

        case (r_state)
            ST_RUN: begin
                if (stall) begin
                    // hold everything
                end else if (!imem_ready) begin
                    w_stateNext = ST_WAIT;
                end else if (w_fault) begin
                    w_trapPcNext    = r_pc;
                    w_pcNext        = TRAP_VEC;
                    w_trapValidNext = 1'b1;
                    w_stateNext     = ST_TRAP;
                end else begin
                    w_pcNext    = w_seqNext;
                    w_brCntNext = r_brCnt + {31'd0, w_take};
                end
            end
            ST_WAIT: begin
                // The fetched instruction executes in the following RUN
                // cycle, so the PC is left untouched here.
                if (imem_ready && !stall) begin
                    w_stateNext = ST_RUN;
                end
            end
            ST_TRAP: begin
                if (trap_ack) begin
                    w_trapValidNext = 1'b0;
                    w_stateNext     = ST_RUN;
                end
            end
            default: begin
                w_stateNext = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_pc        <= RESET_PC;
            r_trapValid <= 1'b0;
            r_trapPc    <= '0;
            r_brCnt     <= '0;
        end else begin
            r_state     <= w_stateNext;
            r_pc        <= w_pcNext;
            r_trapValid <= w_trapValidNext;
            r_trapPc    <= w_trapPcNext;
            r_brCnt     <= w_brCntNext;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign br_un      = is_branch & funct3[1];
    assign pc         = r_pc;
    assign pc_plus4   = w_pcPlus4;
    assign imem_req   = (r_state != ST_TRAP);
    assign br_taken   = w_take & (r_state == ST_RUN);
    assign trap_valid = r_trapValid;
    assign trap_pc    = r_trapPc;
    assign br_cnt     = r_brCnt;

endmodule : branch_pc_unit
`default_nettype wire
